// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Sequencer between the decoder and the 16x32 register bank.
//            Reads up to two source operands (PC register served from pc_in
//            plus an offset), presents them to execute, and serialises
//            result writebacks into the bank. Every bank access is exactly
//            one rb_trigger toggle.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PC_REG    = 15,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dec_req,
  output logic              dec_ack,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic              use_rm,
  input  logic [DATA_W-1:0] pc_in,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ack,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data_w,
  input  logic [DATA_W-1:0] rb_data_r,
  output logic              rb_rw,
  output logic              rb_trigger
);

  localparam logic [ADDR_W-1:0] c_pc_reg = ADDR_W'(PC_REG);
  localparam logic [DATA_W-1:0] c_pc_off = DATA_W'(PC_OFFSET);

  // A bank read is launched on entry to RD_x and captured when leaving CAP_x,
  // giving the bank two full clock periods to respond to the trigger edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_CAP_A = 3'd2,
    S_RD_B  = 3'd3,
    S_CAP_B = 3'd4,
    S_OUT   = 3'd5,
    S_WB    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Registered outputs
  logic                r_dec_ack;
  logic                r_wb_ack;
  logic                r_op_valid;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [ADDR_W-1:0]   r_rb_addr;
  logic [DATA_W-1:0]   r_rb_data_w;
  logic                r_rb_rw;
  logic                r_rb_trigger;

  // Request fields captured at acceptance
  logic [ADDR_W-1:0]   r_rn;
  logic [ADDR_W-1:0]   r_rm;
  logic                r_use_rm;
  logic [DATA_W-1:0]   r_pc;

  // Next-state values
  logic                w_dec_ack_nxt;
  logic                w_wb_ack_nxt;
  logic                w_op_valid_nxt;
  logic [DATA_W-1:0]   w_op_a_nxt;
  logic [DATA_W-1:0]   w_op_b_nxt;
  logic [ADDR_W-1:0]   w_rb_addr_nxt;
  logic [DATA_W-1:0]   w_rb_data_w_nxt;
  logic                w_rb_rw_nxt;
  logic                w_rb_trigger_nxt;
  logic                w_accept;
  logic                w_to_b;
  logic [DATA_W-1:0]   w_pc_opnd;

  // Operand value substituted for PC_REG reads (wraps modulo 2^DATA_W)
  assign w_pc_opnd = r_pc + c_pc_off;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_dec_ack_nxt    = 1'b0;
    w_wb_ack_nxt     = 1'b0;
    w_op_valid_nxt   = r_op_valid;
    w_op_a_nxt       = r_op_a;
    w_op_b_nxt       = r_op_b;
    w_rb_addr_nxt    = r_rb_addr;
    w_rb_data_w_nxt  = r_rb_data_w;
    w_rb_rw_nxt      = r_rb_rw;
    w_rb_trigger_nxt = r_rb_trigger;
    w_accept         = 1'b0;
    w_to_b           = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Writeback first so a following read observes the new value
        if (wb_req) begin
          w_state_nxt      = S_WB;
          w_rb_addr_nxt    = wb_addr;
          w_rb_data_w_nxt  = wb_data;
          w_rb_rw_nxt      = 1'b0;
          w_rb_trigger_nxt = ~r_rb_trigger;
        end else if (dec_req) begin
          w_accept      = 1'b1;
          w_dec_ack_nxt = 1'b1;
          w_state_nxt   = S_RD_A;
          // PC operand needs no bank access; RD_A then only resolves it
          if (rn != c_pc_reg) begin
            w_rb_addr_nxt    = rn;
            w_rb_rw_nxt      = 1'b1;
            w_rb_trigger_nxt = ~r_rb_trigger;
          end
        end
      end
      S_RD_A: begin
        if (r_rn == c_pc_reg) begin
          w_op_a_nxt = w_pc_opnd;
          w_to_b     = 1'b1;
        end else begin
          w_state_nxt = S_CAP_A;
        end
      end
      S_CAP_A: begin
        w_op_a_nxt = rb_data_r;
        w_to_b     = 1'b1;
      end
      S_RD_B: begin
        w_state_nxt = S_CAP_B;
      end
      S_CAP_B: begin
        w_op_b_nxt     = rb_data_r;
        w_op_valid_nxt = 1'b1;
        w_state_nxt    = S_OUT;
      end
      S_OUT: begin
        if (op_ready) begin
          w_op_valid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end
      S_WB: begin
        w_wb_ack_nxt = 1'b1;
        w_rb_rw_nxt  = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Operand A resolved: either finish, bypass B from PC, or launch B read
    if (w_to_b) begin
      if (!r_use_rm) begin
        w_op_b_nxt     = '0;
        w_op_valid_nxt = 1'b1;
        w_state_nxt    = S_OUT;
      end else if (r_rm == c_pc_reg) begin
        w_op_b_nxt     = w_pc_opnd;
        w_op_valid_nxt = 1'b1;
        w_state_nxt    = S_OUT;
      end else begin
        w_rb_addr_nxt    = r_rm;
        w_rb_rw_nxt      = 1'b1;
        w_rb_trigger_nxt = ~r_rb_trigger;
        w_state_nxt      = S_RD_B;
      end
    end
  end

  // Output registers; reset leaves rb_rw as read so a trigger edge is benign
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dec_ack    <= 1'b0;
      r_wb_ack     <= 1'b0;
      r_op_valid   <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rb_addr    <= '0;
      r_rb_data_w  <= '0;
      r_rb_rw      <= 1'b1;
      r_rb_trigger <= 1'b0;
    end else begin
      r_dec_ack    <= w_dec_ack_nxt;
      r_wb_ack     <= w_wb_ack_nxt;
      r_op_valid   <= w_op_valid_nxt;
      r_op_a       <= w_op_a_nxt;
      r_op_b       <= w_op_b_nxt;
      r_rb_addr    <= w_rb_addr_nxt;
      r_rb_data_w  <= w_rb_data_w_nxt;
      r_rb_rw      <= w_rb_rw_nxt;
      r_rb_trigger <= w_rb_trigger_nxt;
    end
  end

  // Capture the request fields when the decoder is acknowledged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rn     <= '0;
      r_rm     <= '0;
      r_use_rm <= 1'b0;
      r_pc     <= '0;
    end else if (w_accept) begin
      r_rn     <= rn;
      r_rm     <= rm;
      r_use_rm <= use_rm;
      r_pc     <= pc_in;
    end
  end

  assign dec_ack    = r_dec_ack;
  assign wb_ack     = r_wb_ack;
  assign op_valid   = r_op_valid;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign rb_addr    = r_rb_addr;
  assign rb_data_w  = r_rb_data_w;
  assign rb_rw      = r_rb_rw;
  assign rb_trigger = r_rb_trigger;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed self-checking bench for operand_fetch with a
//            behavioural 16x32 bank that acts on both trigger edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic        clk;
  logic        reset_n;
  logic        dec_req;
  logic        dec_ack;
  logic [3:0]  rn;
  logic [3:0]  rm;
  logic        use_rm;
  logic [31:0] pc_in;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wb_req;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic [3:0]  rb_addr;
  logic [31:0] rb_data_w;
  logic [31:0] rb_data_r;
  logic        rb_rw;
  logic        rb_trigger;

  int          n_tests;
  int          n_fail;
  int          n_tog;
  int          n_wr;
  logic [31:0] mem [16];

  operand_fetch #(
    .DATA_W    (32),
    .ADDR_W    (4),
    .PC_REG    (15),
    .PC_OFFSET (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dec_req    (dec_req),
    .dec_ack    (dec_ack),
    .rn         (rn),
    .rm         (rm),
    .use_rm     (use_rm),
    .pc_in      (pc_in),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .wb_req     (wb_req),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ack     (wb_ack),
    .rb_addr    (rb_addr),
    .rb_data_w  (rb_data_w),
    .rb_data_r  (rb_data_r),
    .rb_rw      (rb_rw),
    .rb_trigger (rb_trigger)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: every trigger edge is one access, performed just after it
  always @(rb_trigger) begin
    n_tog = n_tog + 1;
    #1;
    if (rb_rw) begin
      rb_data_r = mem[rb_addr];
    end else begin
      mem[rb_addr] = rb_data_w;
      n_wr = n_wr + 1;
    end
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " dec_ack"},    32'(dec_ack),    32'd0);
    chk({tag, " wb_ack"},     32'(wb_ack),     32'd0);
    chk({tag, " op_valid"},   32'(op_valid),   32'd0);
    chk({tag, " op_a"},       op_a,            32'd0);
    chk({tag, " op_b"},       op_b,            32'd0);
    chk({tag, " rb_addr"},    32'(rb_addr),    32'd0);
    chk({tag, " rb_data_w"},  rb_data_w,       32'd0);
    chk({tag, " rb_rw"},      32'(rb_rw),      32'd1);
    chk({tag, " rb_trigger"}, 32'(rb_trigger), 32'd0);
  endtask

  // Issue a request; acc = edges until dec_ack seen (acceptance edge),
  // lat = edges after the acceptance edge until op_valid is seen.
  task automatic do_fetch(input logic [3:0] a, input logic [3:0] b, input logic u,
                          input logic [31:0] pc, output int acc, output int lat,
                          output logic [31:0] oa, output logic [31:0] ob,
                          output int tog);
    int t0;
    t0      = n_tog;
    rn      = a;
    rm      = b;
    use_rm  = u;
    pc_in   = pc;
    dec_req = 1'b1;
    acc     = 0;
    do begin
      step();
      acc++;
    end while (!dec_ack && acc < 20);
    chk("dec_ack seen", 32'(dec_ack), 32'd1);
    chk("op_valid low with dec_ack", 32'(op_valid), 32'd0);
    dec_req = 1'b0;
    lat     = 0;
    do begin
      step();
      lat++;
      if (lat == 1) chk("dec_ack one-cycle pulse", 32'(dec_ack), 32'd0);
    end while (!op_valid && lat < 30);
    chk("op_valid seen", 32'(op_valid), 32'd1);
    oa  = op_a;
    ob  = op_b;
    tog = n_tog - t0;
  endtask

  initial begin
    int          acc;
    int          lat;
    int          tog;
    int          wr0;
    logic [31:0] oa;
    logic [31:0] ob;

    n_tests   = 0;
    n_fail    = 0;
    n_tog     = 0;
    n_wr      = 0;
    rb_data_r = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[1]   = 32'h0000_0000;
    mem[2]   = 32'h0000_0001;
    reset_n  = 1'b0;
    dec_req  = 1'b0;
    rn       = '0;
    rm       = '0;
    use_rm   = 1'b0;
    pc_in    = '0;
    op_ready = 1'b1;
    wb_req   = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;

    // Reset values
    repeat (3) step();
    chk_reset_outs("reset");
    reset_n = 1'b1;
    step();
    n_tog = 0;

    // Two bank reads: rn=2 (1), rm=1 (0); valid on the 4th edge after
    // acceptance, i.e. visible in cycle 5 when dec_ack is visible in cycle 1
    do_fetch(4'd2, 4'd1, 1'b1, 32'h0, acc, lat, oa, ob, tog);
    chk("2rd latency", 32'(lat), 32'd4);
    chk("2rd op_a", oa, 32'h1);
    chk("2rd op_b", ob, 32'h0);
    chk("2rd toggles", 32'(tog), 32'd2);
    chk("2rd no bank write", 32'(n_wr), 32'd0);
    step();
    chk("2rd op_valid drops", 32'(op_valid), 32'd0);

    // Writeback and fetch together: write wins
    wb_req  = 1'b1;
    wb_addr = 4'd3;
    wb_data = 32'hDEAD_BEEF;
    rn      = 4'd3;
    use_rm  = 1'b0;
    dec_req = 1'b1;
    wr0     = n_tog;
    step();
    chk("wb rb_rw write", 32'(rb_rw), 32'd0);
    chk("wb rb_addr", 32'(rb_addr), 32'd3);
    chk("wb dec not acked", 32'(dec_ack), 32'd0);
    chk("wb one toggle", 32'(n_tog - wr0), 32'd1);
    step();
    chk("wb_ack pulse", 32'(wb_ack), 32'd1);
    chk("wb rb_rw back to read", 32'(rb_rw), 32'd1);
    wb_req = 1'b0;
    chk("wb bank content", mem[3], 32'hDEAD_BEEF);
    chk("wb write count", 32'(n_wr), 32'd1);
    do_fetch(4'd3, 4'd0, 1'b0, 32'h0, acc, lat, oa, ob, tog);
    chk("rd-after-wb accept edge", 32'(acc), 32'd1);
    chk("rd-after-wb latency", 32'(lat), 32'd2);
    chk("rd-after-wb op_a", oa, 32'hDEAD_BEEF);
    chk("rd-after-wb op_b", ob, 32'h0);
    chk("rd-after-wb toggles", 32'(tog), 32'd1);
    step();

    // Both operands from the PC register
    do_fetch(4'd15, 4'd15, 1'b1, 32'h0000_0100, acc, lat, oa, ob, tog);
    chk("pc2 latency", 32'(lat), 32'd1);
    chk("pc2 op_a", oa, 32'h0000_0108);
    chk("pc2 op_b", ob, 32'h0000_0108);
    chk("pc2 toggles", 32'(tog), 32'd0);
    step();

    // PC for A, bank for B
    do_fetch(4'd15, 4'd2, 1'b1, 32'h0000_0200, acc, lat, oa, ob, tog);
    chk("pcA op_a", oa, 32'h0000_0208);
    chk("pcA op_b", ob, 32'h0000_0001);
    chk("pcA toggles", 32'(tog), 32'd1);
    step();

    // Back-pressure: operands held while op_ready is low
    op_ready = 1'b0;
    do_fetch(4'd2, 4'd1, 1'b1, 32'h0, acc, lat, oa, ob, tog);
    chk("bp latency", 32'(lat), 32'd4);
    rn      = 4'd1;
    use_rm  = 1'b0;
    dec_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp op_valid held", 32'(op_valid), 32'd1);
      chk("bp op_a stable", op_a, 32'h1);
      chk("bp op_b stable", op_b, 32'h0);
      chk("bp dec not acked", 32'(dec_ack), 32'd0);
    end
    op_ready = 1'b1;
    step();
    chk("bp op_valid drops", 32'(op_valid), 32'd0);
    do_fetch(4'd1, 4'd0, 1'b0, 32'h0, acc, lat, oa, ob, tog);
    chk("b2b accept next edge", 32'(acc), 32'd1);
    chk("b2b latency", 32'(lat), 32'd2);
    chk("b2b op_a", oa, 32'h0);
    chk("b2b toggles", 32'(tog), 32'd1);
    step();

    // Asynchronous reset while capturing operand A
    wr0     = n_wr;
    rn      = 4'd2;
    use_rm  = 1'b0;
    dec_req = 1'b1;
    step();
    chk("rst-mid accepted", 32'(dec_ack), 32'd1);
    dec_req = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("rst-mid");
    step();
    #3;
    reset_n = 1'b1;
    chk("rst-mid no bank write", 32'(n_wr - wr0), 32'd0);
    do_fetch(4'd2, 4'd1, 1'b1, 32'h0, acc, lat, oa, ob, tog);
    chk("post-rst latency", 32'(lat), 32'd4);
    chk("post-rst op_a", oa, 32'h1);
    chk("post-rst op_b", ob, 32'h0);
    step();

    // PC offset wrap-around
    do_fetch(4'd15, 4'd0, 1'b0, 32'hFFFF_FFFC, acc, lat, oa, ob, tog);
    chk("wrap latency", 32'(lat), 32'd1);
    chk("wrap op_a", oa, 32'h0000_0004);
    chk("wrap op_b", ob, 32'h0);
    chk("wrap toggles", 32'(tog), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
